// File: rtl/norm_sqrt_unit.sv
// Iterative floor square root: norm of a signed pair (mode 0) or raw radicand (mode 1).
// Restoring digit-by-digit, one root bit per cycle, DATA_W iterations per result.
module norm_sqrt_unit #(
    parameter int DATA_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_trig,
    input  logic                  i_mode,
    input  logic [2*DATA_W-1:0]   i_data,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_root,
    output logic                  o_exact
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [2*DATA_W-1:0]   rad_q, rad_d;
    logic [DATA_W+1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     root_q, root_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     root_out_q, root_out_d;
    logic                  exact_q, exact_d;
    logic                  busy_q, valid_q;

    logic signed [DATA_W-1:0]   op_a, op_b;
    logic signed [2*DATA_W-1:0] sq_a, sq_b;
    logic [2*DATA_W-1:0]        rad_in;
    logic [DATA_W+4:0]          trial;
    logic                       root_bit;
    logic [DATA_W+1:0]          rem_iter;
    logic [DATA_W-1:0]          root_iter;
    logic                       accept;

    // Squares are non-negative and their sum peaks at 2^(2*DATA_W-1), so it fits unsigned.
    assign op_a   = i_data[2*DATA_W-1:DATA_W];
    assign op_b   = i_data[DATA_W-1:0];
    assign sq_a   = op_a * op_a;
    assign sq_b   = op_b * op_b;
    assign rad_in = i_mode ? i_data : ($unsigned(sq_a) + $unsigned(sq_b));

    // Extra top bit of the trial subtraction serves as the sign.
    assign trial     = {1'b0, rem_q, rad_q[2*DATA_W-1 -: 2]} - {3'b000, root_q, 2'b01};
    assign root_bit  = ~trial[DATA_W+4];
    assign rem_iter  = root_bit ? trial[DATA_W+1:0] : {rem_q[DATA_W-1:0], rad_q[2*DATA_W-1 -: 2]};
    assign root_iter = {root_q[DATA_W-2:0], root_bit};

    always_comb begin
        state_d    = state_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        cnt_d      = cnt_q;
        root_out_d = root_out_q;
        exact_d    = exact_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: accept = i_trig;
            CALC: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_iter;
                root_d = root_iter;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    root_out_d = root_iter;
                    exact_d    = (rem_iter == '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                accept  = i_trig;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // DONE doubles as an accept cycle so back-to-back runs lose only one cycle.
        if (accept) begin
            state_d = CALC;
            rad_d   = rad_in;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = CNT_W'(DATA_W - 1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            root_out_q <= '0;
            exact_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            cnt_q      <= cnt_d;
            root_out_q <= root_out_d;
            exact_q    <= exact_d;
            busy_q     <= (state_d == CALC);
            valid_q    <= (state_d == DONE);
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_root  = root_out_q;
    assign o_exact = exact_q;

endmodule
